// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the RAM port arbiter.
//   owner_t      : identifies which requester owns a RAM access (none/cpu/ldr)
//   RAM_AW/RAM_DW: RAM address and data widths (256 x 8)
package ram_arb_pkg;

    localparam int RAM_AW = 8;
    localparam int RAM_DW = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_LDR  = 2'b10
    } owner_t;

endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational winner selection between the CPU and the loader.
// Optional feature macro: RAM_ARB_RR_EN (hold-limited round robin). Without it
// the CPU has fixed priority and the history inputs are ignored.
// Ports:
//   i_cpu_req, i_ldr_req : requests for this cycle
//   i_last_owner         : owner granted in the previous cycle (none after idle)
//   i_hold_cnt           : consecutive grants given to i_last_owner
//   o_cpu_win, o_ldr_win : one-hot (or zero) winner
import ram_arb_pkg::*;

module ram_arb_pick #(
    parameter int MAX_HOLD = 4
) (
    input  logic       i_cpu_req,
    input  logic       i_ldr_req,
    input  owner_t     i_last_owner,
    input  logic [3:0] i_hold_cnt,
    output logic       o_cpu_win,
    output logic       o_ldr_win
);

`ifdef RAM_ARB_RR_EN
    logic w_keep;

    // The current owner may keep the RAM until it has used its hold budget.
    assign w_keep = (i_hold_cnt < 4'(MAX_HOLD));

    always_comb begin
        o_cpu_win = i_cpu_req;
        o_ldr_win = i_ldr_req;
        if (i_cpu_req && i_ldr_req) begin
            case (i_last_owner)
                OWN_CPU: begin
                    o_cpu_win = w_keep;
                    o_ldr_win = ~w_keep;
                end
                OWN_LDR: begin
                    o_cpu_win = ~w_keep;
                    o_ldr_win = w_keep;
                end
                // No history: the CPU wins.
                default: o_ldr_win = 1'b0;
            endcase
        end
    end
`else
    logic       w_unused_owner;
    logic [3:0] w_unused_hold;

    assign o_cpu_win = i_cpu_req;
    assign o_ldr_win = i_ldr_req & ~i_cpu_req;

    // History is meaningless under fixed priority.
    assign w_unused_owner = ^i_last_owner;
    assign w_unused_hold  = i_hold_cnt ^ 4'(MAX_HOLD);
`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the single-port 256x8 synchronous RAM between the
// CPU and the program loader/debug port. One access per cycle, grant in the
// same cycle, ack plus read data one cycle later (registered RAM read).
// Optional feature macro: RAM_ARB_RR_EN (hold-limited round robin, MAX_HOLD).
// Ports:
//   clk, rst_n                         : clock, async active-low reset
//   cpu_req/we/addr/wdata, cpu_gnt     : CPU request side and same-cycle grant
//   cpu_ack, cpu_rdata                 : CPU completion, data valid with ack
//   ldr_*                              : same set for the loader
//   ram_addr, ram_data, ram_we, ram_q  : RAM connection
import ram_arb_pkg::*;

module ram_port_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [RAM_AW-1:0] cpu_addr,
    input  logic [RAM_DW-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_ack,
    output logic [RAM_DW-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [RAM_AW-1:0] ldr_addr,
    input  logic [RAM_DW-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_ack,
    output logic [RAM_DW-1:0] ldr_rdata,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [RAM_DW-1:0] ram_data,
    output logic              ram_we,
    input  logic [RAM_DW-1:0] ram_q
);

    owner_t            r_rd_owner;
    owner_t            w_last_owner;
    owner_t            w_win_owner;
    logic [3:0]        w_hold_cnt;
    logic              w_cpu_win;
    logic              w_ldr_win;
    logic [RAM_AW-1:0] r_addr;
    logic [RAM_DW-1:0] r_data;

    ram_arb_pick #(
        .MAX_HOLD (MAX_HOLD)
    ) u_pick (
        .i_cpu_req    (cpu_req),
        .i_ldr_req    (ldr_req),
        .i_last_owner (w_last_owner),
        .i_hold_cnt   (w_hold_cnt),
        .o_cpu_win    (w_cpu_win),
        .o_ldr_win    (w_ldr_win)
    );

    // No access may reach the RAM while reset is held.
    assign cpu_gnt = w_cpu_win & rst_n;
    assign ldr_gnt = w_ldr_win & rst_n;

    assign w_win_owner = cpu_gnt ? OWN_CPU : (ldr_gnt ? OWN_LDR : OWN_NONE);

    // Idle cycles replay the last granted address/data so the RAM pins stay quiet.
    assign ram_addr = cpu_gnt ? cpu_addr  : (ldr_gnt ? ldr_addr  : r_addr);
    assign ram_data = cpu_gnt ? cpu_wdata : (ldr_gnt ? ldr_wdata : r_data);
    assign ram_we   = (cpu_gnt & cpu_we) | (ldr_gnt & ldr_we);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_owner <= OWN_NONE;
            r_addr     <= '0;
            r_data     <= '0;
        end else begin
            r_rd_owner <= w_win_owner;
            if (cpu_gnt || ldr_gnt) begin
                r_addr <= ram_addr;
                r_data <= ram_data;
            end
        end
    end

    assign cpu_ack   = (r_rd_owner == OWN_CPU);
    assign ldr_ack   = (r_rd_owner == OWN_LDR);
    assign cpu_rdata = cpu_ack ? ram_q : '0;
    assign ldr_rdata = ldr_ack ? ram_q : '0;

`ifdef RAM_ARB_RR_EN
    owner_t     r_last_owner;
    logic [3:0] r_hold_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_owner <= OWN_NONE;
            r_hold_cnt   <= '0;
        end else if (w_win_owner == OWN_NONE) begin
            r_last_owner <= OWN_NONE;
            r_hold_cnt   <= '0;
        end else if (w_win_owner == r_last_owner) begin
            if (r_hold_cnt < 4'(MAX_HOLD)) begin
                r_hold_cnt <= r_hold_cnt + 4'd1;
            end
        end else begin
            r_last_owner <= w_win_owner;
            r_hold_cnt   <= 4'd1;
        end
    end

    assign w_last_owner = r_last_owner;
    assign w_hold_cnt   = r_hold_cnt;
`else
    assign w_last_owner = OWN_NONE;
    assign w_hold_cnt   = '0;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

    localparam int MAXH = 4;
`ifdef RAM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       cpu_req, cpu_we, ldr_req, ldr_we;
    logic [7:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
    logic       cpu_gnt, cpu_ack, ldr_gnt, ldr_ack;
    logic [7:0] cpu_rdata, ldr_rdata;
    logic [7:0] ram_addr, ram_data, ram_q;
    logic       ram_we;

    ram_port_arbiter #(.MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .ldr_req   (ldr_req),
        .ldr_we    (ldr_we),
        .ldr_addr  (ldr_addr),
        .ldr_wdata (ldr_wdata),
        .ldr_gnt   (ldr_gnt),
        .ldr_ack   (ldr_ack),
        .ldr_rdata (ldr_rdata),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .ram_we    (ram_we),
        .ram_q     (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous read-before-write RAM driven by the arbiter.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        ram_q <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_data;
    end

    // Reference model: memory image, winner history and the pending completion.
    logic [7:0] ref_mem [256];
    int         m_last, m_streak, m_pend, last_win;
    logic [7:0] m_pend_data, m_addr, m_data;
    int         checks, errors;
    logic       s_cpu_gnt, s_ldr_gnt, s_cpu_ack, s_ldr_ack;
    logic [7:0] s_cpu_rdata, s_ldr_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // 0 = nobody, 1 = cpu, 2 = ldr
    function automatic int model_pick(input bit c, input bit l);
        if (c && l) begin
            if (RR_EN && m_last != 0 && m_streak < MAXH) return m_last;
            if (RR_EN && m_last != 0) return 3 - m_last;
            return 1;
        end
        if (c) return 1;
        if (l) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_last = 0; m_streak = 0; m_pend = 0;
        m_pend_data = 8'h00; m_addr = 8'h00; m_data = 8'h00;
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic cyc(input bit cr, input bit cw, input logic [7:0] ca, input logic [7:0] cd,
                       input bit lr, input bit lw, input logic [7:0] la, input logic [7:0] ld);
        int w;
        logic [7:0] wa, wd;
        bit wwe;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        ldr_req = lr; ldr_we = lw; ldr_addr = la; ldr_wdata = ld;
        w = model_pick(cr, lr);
        if (w == 1)      begin wa = ca; wd = cd; wwe = cw; end
        else if (w == 2) begin wa = la; wd = ld; wwe = lw; end
        else             begin wa = m_addr; wd = m_data; wwe = 1'b0; end
        @(negedge clk);
        s_cpu_gnt = cpu_gnt; s_ldr_gnt = ldr_gnt;
        s_cpu_ack = cpu_ack; s_ldr_ack = ldr_ack;
        s_cpu_rdata = cpu_rdata; s_ldr_rdata = ldr_rdata;
        chk("cpu_gnt", cpu_gnt, w == 1);
        chk("ldr_gnt", ldr_gnt, w == 2);
        chk("ram_we", ram_we, wwe);
        chk("ram_addr", ram_addr, wa);
        chk("ram_data", ram_data, wd);
        chk("cpu_ack", cpu_ack, m_pend == 1);
        chk("ldr_ack", ldr_ack, m_pend == 2);
        chk("cpu_rdata", cpu_rdata, (m_pend == 1) ? m_pend_data : 8'h00);
        chk("ldr_rdata", ldr_rdata, (m_pend == 2) ? m_pend_data : 8'h00);
        m_pend = w;
        if (w != 0) begin
            m_pend_data = ref_mem[wa];
            if (wwe) ref_mem[wa] = wd;
            m_addr = wa;
            m_data = wd;
        end
        if (w == 0) begin m_last = 0; m_streak = 0; end
        else if (w == m_last) m_streak++;
        else begin m_last = w; m_streak = 1; end
        last_win = w;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    endtask

    initial begin
        bit         cr, cw, lr, lw, c_hold, l_hold;
        logic [7:0] ca, cd, la, ld, v;
        checks = 0; errors = 0; last_win = 0;
        model_reset();
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            mem[i] = v; ref_mem[i] = v;
        end
        mem[8'h05] = 8'h3C; ref_mem[8'h05] = 8'h3C;
        mem[8'h10] = 8'h5A; ref_mem[8'h10] = 8'h5A;
        mem[8'h20] = 8'h11; ref_mem[8'h20] = 8'h11;

        rst_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
        #2;
        chk("rst_cpu_ack", cpu_ack, 1'b0);
        chk("rst_ldr_ack", ldr_ack, 1'b0);
        chk("rst_cpu_rdata", cpu_rdata, 8'h00);
        chk("rst_ldr_rdata", ldr_rdata, 8'h00);
        chk("rst_ram_addr", ram_addr, 8'h00);
        chk("rst_ram_data", ram_data, 8'h00);
        cpu_req = 1; cpu_we = 1; ldr_req = 1;
        #1;
        chk("rst_cpu_gnt", cpu_gnt, 1'b0);
        chk("rst_ldr_gnt", ldr_gnt, 1'b0);
        chk("rst_ram_we", ram_we, 1'b0);
        cpu_req = 0; cpu_we = 0; ldr_req = 0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // CPU-only read
        cyc(1, 0, 8'h05, 8'h00, 0, 0, 8'h00, 8'h00);
        chk("t1_gnt", s_cpu_gnt, 1'b1);
        idle();
        chk("t1_ack", s_cpu_ack, 1'b1);
        chk("t1_rdata", s_cpu_rdata, 8'h3C);
        chk("t1_ldr_ack", s_ldr_ack, 1'b0);

        // Loader write then CPU read of the same address
        cyc(0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 8'hA5);
        cyc(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
        chk("t2_ldr_ack", s_ldr_ack, 1'b1);
        chk("t2_ldr_old", s_ldr_rdata, 8'h5A);
        idle();
        chk("t2_cpu_rdata", s_cpu_rdata, 8'hA5);

        // Both requesting for 12 cycles
        idle();
        for (int i = 0; i < 12; i++) begin
            cyc(1, 0, 8'h30, 8'h00, 1, 0, 8'h31, 8'h00);
            chk("t3_ldr_gnt", s_ldr_gnt, RR_EN && i >= 4 && i < 8);
            chk("t3_cpu_gnt", s_cpu_gnt, !(RR_EN && i >= 4 && i < 8));
        end
        idle();

        // Loader alone: no forced gaps
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 8'h00, 8'h00, 1, 0, 8'(i), 8'h00);
            chk("t4_ldr_gnt", s_ldr_gnt, 1'b1);
        end
        idle();

        // Reset while a CPU read is outstanding
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h40; cpu_wdata = 8'h00;
        ldr_req = 0; ldr_we = 0;
        @(negedge clk);
        chk("t5_gnt", cpu_gnt, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t5_gnt_rst", cpu_gnt, 1'b0);
        chk("t5_we_rst", ram_we, 1'b0);
        chk("t5_ack_rst", cpu_ack, 1'b0);
        chk("t5_addr_rst", ram_addr, 8'h00);
        @(posedge clk); #1;
        chk("t5_ack_edge", cpu_ack, 1'b0);
        rst_n = 1'b1;
        cpu_req = 0;
        model_reset();
        idle();
        chk("t5_no_ack", s_cpu_ack, 1'b0);
        chk("t5_rdata", s_cpu_rdata, 8'h00);

        // Write ack returns the old contents
        cyc(1, 1, 8'h20, 8'h77, 0, 0, 8'h00, 8'h00);
        idle();
        chk("t6_ack", s_cpu_ack, 1'b1);
        chk("t6_old", s_cpu_rdata, 8'h11);
        cyc(1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00);
        idle();
        chk("t6_new", s_cpu_rdata, 8'h77);

        // Random traffic; a denied requester holds its request stable
        cr = 0; cw = 0; ca = 0; cd = 0; lr = 0; lw = 0; la = 0; ld = 0;
        c_hold = 0; l_hold = 0;
        for (int i = 0; i < 400; i++) begin
            if (!c_hold) begin
                cr = ($urandom_range(0, 3) != 0);
                cw = 1'($urandom); ca = 8'($urandom); cd = 8'($urandom);
            end
            if (!l_hold) begin
                lr = ($urandom_range(0, 3) != 0);
                lw = 1'($urandom); la = 8'($urandom); ld = 8'($urandom);
            end
            cyc(cr, cw, ca, cd, lr, lw, la, ld);
            c_hold = cr && (last_win != 1);
            l_hold = lr && (last_win != 2);
        end
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
